intr_button_conditioner: RTL and testbench

//  Conditions the raw interrupt push-button (buttons[4]) before it reaches the OTTER

---
 rtl/intr_button_conditioner.sv | 139 +++++++++++++
 tb/tb_intr_button_conditioner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/intr_button_conditioner.sv
// Interrupt push-button conditioner: 2-flop sync, press/release debounce, one IRQ per press.
// Build option INTR_HOLD_EN: intr_out held until intr_ack (else fixed-width pulse).
module intr_button_conditioner #(
  parameter int unsigned DB_CYCLES    = 500000,
  parameter int unsigned PULSE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  input  logic       intr_ack,
  output logic       intr_out,
  output logic       btn_level,
  output logic [7:0] press_count
);

  localparam int unsigned DW = $clog2(DB_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX  = DW'(DB_CYCLES);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    FIRE,
    HELD,
    RELEASE
  } state_t;

  state_t        state;
  logic [DW-1:0] db_cnt;
  logic          sync1;
  logic          btn_s;
  logic          fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn_in;
      btn_s <= sync1;
    end
  end

  assign fire = (state == FIRE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      db_cnt      <= '0;
      btn_level   <= 1'b0;
      press_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_s) begin
            state  <= PRESS;
            db_cnt <= DB_ONE;
          end
        end
        PRESS: begin
          if (!btn_s) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state <= FIRE;
          end else if (db_cnt != DB_MAX) begin
            db_cnt <= db_cnt + DB_ONE;
          end
        end
        FIRE: begin
          state       <= HELD;
          db_cnt      <= '0;
          btn_level   <= 1'b1;
          press_count <= press_count + 8'd1;
        end
        HELD: begin
          if (!btn_s) begin
            state  <= RELEASE;
            db_cnt <= DB_ONE;
          end
        end
        RELEASE: begin
          if (btn_s) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state     <= IDLE;
            db_cnt    <= '0;
            btn_level <= 1'b0;
          end else if (db_cnt != DB_MAX) begin
            db_cnt <= db_cnt + DB_ONE;
          end
        end
        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

`ifdef INTR_HOLD_EN
  // A fire in the same cycle as an ack wins, so a fresh request is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      intr_out <= 1'b0;
    end else if (fire) begin
      intr_out <= 1'b1;
    end else if (intr_ack && intr_out) begin
      intr_out <= 1'b0;
    end
  end
`else
  localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [PW-1:0] P_LOAD = PW'(PULSE_CYCLES);
  localparam logic [PW-1:0] P_ONE  = PW'(1);

  logic [PW-1:0] pcnt;
  logic          unused_ack;

  assign unused_ack = intr_ack;

  // Re-fire reloads the counter, stretching the active pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt     <= '0;
      intr_out <= 1'b0;
    end else if (fire) begin
      pcnt     <= P_LOAD;
      intr_out <= 1'b1;
    end else if (pcnt != '0) begin
      pcnt     <= pcnt - P_ONE;
      intr_out <= (pcnt > P_ONE);
    end
  end
`endif

endmodule

// File: tb/tb_intr_button_conditioner.sv
// Bench for intr_button_conditioner: directed + random stimulus vs a run-length model.
// Build with INTR_HOLD_EN to exercise hold mode.
module tb_intr_button_conditioner;

  localparam int DB = 4;
  localparam int P  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_in = 1'b0;
  logic       intr_ack = 1'b0;
  logic       intr_out;
  logic       btn_level;
  logic [7:0] press_count;

  int checks = 0;
  int fails  = 0;

  intr_button_conditioner #(
    .DB_CYCLES   (DB),
    .PULSE_CYCLES(P)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .intr_ack   (intr_ack),
    .intr_out   (intr_out),
    .btn_level  (btn_level),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  // Model: button samples reach the debouncer 2 edges late; the debounced
  // level flips after DB consecutive opposite samples; a press fires one
  // edge after its DB-th sample (that edge's sample is ignored).
  bit m_q[2];
  int m_run;
  bit m_pend;
  bit m_level;
  bit m_intr;
  int m_left;
  int m_cnt;

  function automatic void model_edge(bit r, bit b, bit a);
    bit bs;
    bit f;
    if (!r) begin
      m_q[0] = 0; m_q[1] = 0;
      m_run = 0; m_pend = 0; m_level = 0;
      m_intr = 0; m_left = 0; m_cnt = 0;
      return;
    end
    bs = m_q[1];
    m_q[1] = m_q[0];
    m_q[0] = b;
    f = 0;
    if (m_pend) begin
      f = 1;
      m_pend = 0;
      m_level = 1;
      m_cnt = (m_cnt + 1) % 256;
      m_run = 0;
    end else begin
      if (bs != m_level) m_run++;
      else m_run = 0;
      if (m_run == DB) begin
        m_run = 0;
        if (m_level) m_level = 0;
        else m_pend = 1;
      end
    end
`ifdef INTR_HOLD_EN
    if (f) m_intr = 1;
    else if (a) m_intr = 0;
`else
    if (f) m_left = P;
    else if (m_left > 0) m_left--;
    m_intr = (m_left > 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic b, input logic a);
    @(negedge clk);
    rst_n    = r;
    btn_in   = b;
    intr_ack = a;
    @(posedge clk);
    model_edge(r, b, a);
    #1;
    chk("intr_out", {7'd0, intr_out}, {7'd0, m_intr});
    chk("btn_level", {7'd0, btn_level}, {7'd0, m_level});
    chk("press_count", press_count, m_cnt[7:0]);
  endtask

  initial begin
    int first;
    int highs;
    int fall;
    int len;
    bit v;
    bit a;

    // Reset with btn_in unknown then low
    step(0, 1'bx, 0);
    step(0, 0, 0);
    chk("reset_intr", {7'd0, intr_out}, 8'd0);
    chk("reset_level", {7'd0, btn_level}, 8'd0);
    chk("reset_count", press_count, 8'd0);

    // Clean press held 20 cycles
    first = 0;
    highs = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1, 1, 0);
      if (intr_out === 1'b1) begin
        highs++;
        if (first == 0) first = i;
      end
    end
    chk("press_latency", first[7:0], 8'd7);
`ifndef INTR_HOLD_EN
    chk("pulse_width", highs[7:0], 8'(P));
`endif
    chk("press_count1", press_count, 8'd1);
    chk("level_high", {7'd0, btn_level}, 8'd1);

    // Release with a 2-cycle glitch
    fall = 0;
    for (int i = 1; i <= 14; i++) begin
      step(1, (i == 2 || i == 3), 0);
      if (btn_level === 1'b0 && fall == 0) fall = i;
    end
    chk("release_fall", fall[7:0], 8'd9);
    chk("release_nofire", press_count, 8'd1);

    // Bounce: never DB consecutive highs
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, ((i / 2) % 2 == 0), 0);
      if (intr_out === 1'b1) highs++;
    end
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    chk("bounce_nofire", highs[7:0], 8'd0);
    chk("bounce_count", press_count, 8'd1);

    // Random bouncy segments with random ack
    for (int s = 0; s < 300; s++) begin
      v = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * DB + 2);
      for (int i = 0; i < len; i++) begin
        a = ($urandom_range(0, 3) == 0);
        step(1, v, a);
      end
    end
    for (int i = 0; i < 12; i++) step(1, 0, 0);

`ifdef INTR_HOLD_EN
    step(0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0);
    for (int i = 0; i < 50; i++) begin
      step(1, 1, 0);
      chk("hold_high", {7'd0, intr_out}, 8'd1);
    end
    step(1, 1, 1);
    chk("hold_ack_clear", {7'd0, intr_out}, 8'd0);
    step(1, 1, 1);
    chk("hold_ack_idle", {7'd0, intr_out}, 8'd0);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 1, m_pend);
    chk("hold_fire_wins", {7'd0, intr_out}, 8'd1);
    chk("hold_count", press_count, 8'd2);
    for (int i = 0; i < 10; i++) step(1, 0, 1);
`endif

    // Reset mid-PRESS with button kept high
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    step(0, 1, 0);
    chk("midreset_count", press_count, 8'd0);
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1, 1, 0);
      if (intr_out === 1'b1 && first == 0) first = i;
    end
    chk("midreset_latency", first[7:0], 8'd7);
    chk("midreset_count1", press_count, 8'd1);

    // 256 presses wrap the counter
    step(0, 0, 0);
    for (int n = 1; n <= 256; n++) begin
      for (int i = 0; i < DB + 4; i++) step(1, 1, 1);
      for (int i = 0; i < DB + 4; i++) step(1, 0, 1);
      if (n == 255) chk("count_255", press_count, 8'd255);
    end
    chk("count_wrap", press_count, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
